// File: rtl/inexrecur_reader_pkg.sv
// Shared accelerator constants for the regfile blocks: default widths and the
// reader FSM state encodings.
package inexrecur_reader_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/inexrecur_reader.sv
// Burst reader: walks a regfile ascending or descending from a start address
// and streams the words through a single valid/ready output register stage.
module inexrecur_reader
    import inexrecur_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              dir,
    output logic              busy,
    output logic              done,
    output logic              ran_re,
    output logic [ADDR_W-1:0] ran_r_addr,
    input  logic [DATA_W-1:0] ran_r_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic              dir_q;
    logic              fetch;
    logic              handshake;

    // Modular step: natural overflow of the ADDR_W-bit sum gives the wrap.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic              down);
        return down ? (a - ADDR_ONE) : (a + ADDR_ONE);
    endfunction

    always_comb begin
        fetch      = (state_q == ST_RUN) && (remaining != CNT_ZERO) &&
                     (!out_valid || out_ready);
        handshake  = out_valid && out_ready;
        ran_re     = fetch;
        ran_r_addr = fetch ? cur_addr : '0;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (count != CNT_ZERO) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (handshake && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst bookkeeping: latched on acceptance, advanced on every fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            dir_q     <= 1'b0;
        end else if ((state_q == ST_IDLE) && start) begin
            cur_addr  <= start_addr;
            remaining <= count;
            dir_q     <= dir;
        end else if (fetch) begin
            cur_addr  <= step_addr(cur_addr, dir_q);
            remaining <= remaining - CNT_ONE;
        end
    end

    // Output stage: a fetch refills it, a bare handshake empties it,
    // otherwise it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (fetch) begin
            out_valid <= 1'b1;
            out_last  <= (remaining == CNT_ONE);
            out_data  <= ran_r_data;
        end else if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inexrecur_reader.sv
// Directed bench for inexrecur_reader: table-driven bursts against a regfile
// model plus hand-written backpressure, count=0, busy-start and reset cases.
module tb_inexrecur_reader;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic          dir;
    logic          busy;
    logic          done;
    logic          ran_re;
    logic [AW-1:0] ran_r_addr;
    logic [DW-1:0] ran_r_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    logic [DW-1:0] mem [0:4095];

    int checks;
    int errors;

    logic [DW-1:0] got [16];
    int            n_got;
    int            n_done;
    int            n_vld;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW:0]   cnt;
        logic          dir;
        logic [AW-1:0] last_addr;
        logic [DW-1:0] last_data;
    } vec_t;

    vec_t vecs [6];

    inexrecur_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .ran_re     (ran_re),
        .ran_r_addr (ran_r_addr),
        .ran_r_data (ran_r_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    assign ran_r_data = mem[ran_r_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        logic [AW-1:0] a;
        @(negedge clk);
        start = 1'b1; start_addr = v.addr; count = v.cnt; dir = v.dir; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("no_valid_yet", out_valid, 0);
        a = v.addr;
        for (int i = 0; i < int'(v.cnt); i++) begin
            check("ran_re", ran_re, 1);
            check("ran_r_addr", ran_r_addr, a);
            if (i == int'(v.cnt) - 1) check("final_addr", ran_r_addr, v.last_addr);
            @(negedge clk);
            check("out_valid", out_valid, 1);
            check("out_data", out_data, mem[a]);
            check("out_last", out_last, (i == int'(v.cnt) - 1));
            if (i == int'(v.cnt) - 1) check("final_data", out_data, v.last_data);
            a = v.dir ? a - 12'd1 : a + 12'd1;
        end
        check("ran_re_after_last", ran_re, 0);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("valid_cleared", out_valid, 0);
        @(negedge clk);
        check("done_low", done, 0);
        check("busy_low", busy, 0);
    endtask

    // Samples handshakes/done for cyc cycles with out_ready=1; optionally
    // pulses start (addr 4094, count 1) at cycle inject_at.
    task automatic collect(input int cyc, input int inject_at);
        n_got = 0; n_done = 0; n_vld = 0;
        out_ready = 1'b1;
        for (int c = 0; c < cyc; c++) begin
            if (out_valid) n_vld++;
            if (out_valid && out_ready && n_got < 16) begin
                got[n_got] = out_data;
                n_got++;
            end
            if (done) n_done++;
            if (c == inject_at) begin
                start = 1'b1; start_addr = 12'd4094; count = 13'd1; dir = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; dir = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int i = 0; i < 5; i++) mem[i] = 32'h10 + i;
        mem[4094] = 32'hAA;
        mem[4095] = 32'hBB;

        vecs[0] = '{addr: 12'd0,    cnt: 13'd5, dir: 1'b0, last_addr: 12'd4,    last_data: 32'h14};
        vecs[1] = '{addr: 12'd4,    cnt: 13'd5, dir: 1'b1, last_addr: 12'd0,    last_data: 32'h10};
        vecs[2] = '{addr: 12'd4094, cnt: 13'd4, dir: 1'b0, last_addr: 12'd1,    last_data: 32'h11};
        vecs[3] = '{addr: 12'd3,    cnt: 13'd4, dir: 1'b1, last_addr: 12'd0,    last_data: 32'h10};
        vecs[4] = '{addr: 12'd5,    cnt: 13'd2, dir: 1'b0, last_addr: 12'd6,    last_data: 32'h0};
        vecs[5] = '{addr: 12'd1,    cnt: 13'd3, dir: 1'b1, last_addr: 12'd4095, last_data: 32'hBB};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ran_re", ran_re, 0);
        check("rst_ran_r_addr", ran_r_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) run_burst(vecs[k]);

        // Backpressure: three stalled cycles on the first word.
        @(negedge clk);
        start = 1'b1; start_addr = 12'd0; count = 13'd5; dir = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("bp_first_fetch", ran_re, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid_held", out_valid, 1);
            check("bp_data_held", out_data, 32'h10);
            check("bp_last_held", out_last, 0);
            check("bp_no_fetch", ran_re, 0);
        end
        collect(12, -1);
        check("bp_word_count", n_got, 5);
        for (int i = 0; i < 5; i++) check("bp_word", got[i], 32'h10 + i);
        check("bp_done_count", n_done, 1);
        check("bp_busy_end", busy, 0);

        // count=0: straight to DONE, single done cycle, no data.
        @(negedge clk);
        start = 1'b1; start_addr = 12'd2; count = 13'd0; dir = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("c0_done", done, 1);
        check("c0_busy", busy, 1);
        check("c0_ran_re", ran_re, 0);
        check("c0_valid", out_valid, 0);
        collect(5, -1);
        check("c0_extra_done", n_done, 1);
        check("c0_no_valid", n_vld, 0);
        check("c0_idle", busy, 0);

        // start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; start_addr = 12'd0; count = 13'd5; dir = 1'b0;
        @(negedge clk);
        start = 1'b0;
        collect(12, 1);
        check("ign_word_count", n_got, 5);
        for (int i = 0; i < 5; i++) check("ign_word", got[i], 32'h10 + i);
        check("ign_done_count", n_done, 1);
        check("ign_idle", busy, 0);

        // Reset mid-burst: immediate clear, no done for the abandoned burst.
        @(negedge clk);
        start = 1'b1; start_addr = 12'd0; count = 13'd5; dir = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_valid_before_rst", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_ran_re", ran_re, 0);
        check("mid_rst_addr", ran_r_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        collect(6, -1);
        check("mid_no_done", n_done, 0);
        check("mid_no_valid", n_vld, 0);
        run_burst(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inexrecur_reader.md
INEXRECUR_READER -- requirements
Module: inexrecur_reader

Interface
REQ-001 Parameter ADDR_W, default 12, width of the regfile address and the start address.
REQ-002 Parameter DATA_W, default 32, width of a regfile entry and the output data.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a burst; ignored while busy=1.
REQ-006 start_addr  input  ADDR_W  first regfile address of the burst.
REQ-007 count  input  ADDR_W+1  number of entries to read, 0..4096.
REQ-008 dir  input  1  0 = ascending addresses, 1 = descending (LIFO walk).
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  one-cycle pulse when the burst completes.
REQ-011 ran_re  output  1  random-read enable to the regfile.
REQ-012 ran_r_addr  output  ADDR_W  random-read address to the regfile.
REQ-013 ran_r_data  input  DATA_W  combinational regfile read data; 0 when the address is unwritten.
REQ-014 out_valid  output  1  output word valid.
REQ-015 out_data  output  DATA_W  output word.
REQ-016 out_last  output  1  high with the final word of a burst.
REQ-017 out_ready  input  1  downstream accept.

Function
REQ-018 FSM states: IDLE, RUN, DONE; the state register holds exactly these three encodings.
REQ-019 IDLE: on start=1, latch start_addr into cur_addr, count into remaining and dir into dir_q; go to RUN if count!=0, else to DONE.
REQ-020 fetch condition: state=RUN, remaining!=0 and (out_valid=0 or out_ready=1); ran_re equals the fetch condition.
REQ-021 ran_r_addr = cur_addr whenever ran_re=1, and 0 otherwise.
REQ-022 On a fetch edge: out_data <= ran_r_data, out_valid <= 1, out_last <= (remaining==1), remaining decrements, and cur_addr steps +1 (dir_q=0) or -1 (dir_q=1).
REQ-023 Address stepping wraps modulo 2^ADDR_W (4095+1 -> 0, 0-1 -> 4095).
REQ-024 A handshake (out_valid and out_ready) with no simultaneous fetch clears out_valid and out_last.
REQ-025 Out registers hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-026 Throughput is one word per cycle while out_ready=1; first out_valid appears two edges after start is sampled.
REQ-027 RUN -> DONE on the handshake of the word with out_last=1.
REQ-028 DONE lasts one cycle with done=1, then returns to IDLE; busy=0 in IDLE only.
REQ-029 count=0: no ran_re, no out_valid, done pulses one cycle after the IDLE->DONE transition.
REQ-030 count=4096 reads every address exactly once, ending at start_addr-1 (ascending) or start_addr+1 (descending).
REQ-031 Data equal to 0 passes through unchanged; the block performs no validity filtering.

Reset
REQ-032 rst_n=0 asynchronously forces state=IDLE, cur_addr=0, remaining=0, dir_q=0, out_valid=0, out_last=0, out_data=0, done=0, busy=0, ran_re=0.
REQ-033 Reset during RUN abandons the burst without a done pulse; the first start after rst_n rises is accepted normally.

Structure
REQ-034 ADDR_W/DATA_W defaults and the IDLE/RUN/DONE state encodings live in the shared accelerator constants header used by the regfile blocks.
REQ-035 The block is a single module with no sub-modules; the output register stage is inline.

Verification
REQ-036 Regfile preloaded with 0x10..0x14 at addresses 0..4, start_addr=0, count=5, dir=0, out_ready=1 -> out_data 0x10,0x11,0x12,0x13,0x14 on consecutive cycles, out_last with 0x14, done one cycle later.
REQ-037 Same preload, start_addr=4, count=5, dir=1 -> out_data 0x14 down to 0x10, ran_r_addr 4,3,2,1,0.
REQ-038 start_addr=4094, count=4, dir=0 -> ran_r_addr 4094,4095,0,1.
REQ-039 out_ready held 0 for 3 cycles after the first word -> out_data stays 0x10, ran_re=0, and the stream resumes with no word lost or duplicated.
REQ-040 count=0 -> no out_valid, done high exactly one cycle; start pulsed while busy -> ignored.
REQ-041 rst_n asserted mid-burst -> all outputs 0 immediately; done never pulses for that burst.
